fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register, sitting directly upstream of the hazard unit and consuming its `flush_ctrl` and `stall_ctrl`. The block holds the PC, addresses instruction memory, and latches the fetched word into the IF/ID register. On a stall it freezes PC and IF/ID. On a flush it redirects PC to the branch target and squashes the IF/ID slot to a NOP. It also keeps saturating stall/flush event counters for debug.

---
 rtl/fetch_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with PC, IF/ID pipeline register and
// saturating stall/flush debug counters. Hazard controls are sampled on posedge;
// priority is flush > stall > advance.
module fetch_stage #(
    parameter int                      ADDR_WIDTH  = 16,
    parameter int                      INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = '0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    stall_ctrl,
    input  logic                    flush_ctrl,
    input  logic [ADDR_WIDTH-1:0]   branch_target,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    input  logic [INSTR_WIDTH-1:0]  imem_data,
    output logic [INSTR_WIDTH-1:0]  if_id_instr,
    output logic [ADDR_WIDTH-1:0]   if_id_pc,
    output logic                    if_id_valid,
    output logic [1:0]              fetch_state,
    output logic [15:0]             stall_cycles,
    output logic [7:0]              flush_count
);

    // Control semantics: there is no valid/ready handshake here. stall_ctrl and
    // flush_ctrl are level commands sampled once per posedge. if_id_valid marks
    // that the IF/ID slot holds a real instruction; the consumer never
    // back-pressures this block except through stall_ctrl from the hazard unit.

    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STALL    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]    ifpc_q, ifpc_d;
    logic                     valid_q, valid_d;
    logic [15:0]              stall_cnt_q, stall_cnt_d;
    logic [7:0]               flush_cnt_q, flush_cnt_d;

    // FSM state register; FILL only ever comes from reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the state records which action the last edge took.
    always_comb begin
        state_d = state_q;
        if (flush_ctrl) begin
            state_d = ST_REDIRECT;
        end else if (stall_ctrl) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_RUN;
        end
    end

    // FSM output: expose the state for debug.
    always_comb begin
        fetch_state = state_q;
    end

    // Datapath next-state: PC, IF/ID slot and saturating event counters.
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        ifpc_d      = ifpc_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush_ctrl) begin
            // Redirect and squash; a simultaneous stall is discarded.
            pc_d    = branch_target;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            if (flush_cnt_q != 8'hFF) begin
                flush_cnt_d = flush_cnt_q + 8'd1;
            end
        end else if (stall_ctrl) begin
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end else begin
            // Advance: latch the word at the current PC, PC wraps naturally.
            instr_d = imem_data;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_ONE;
        end
    end

    // Datapath registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            ifpc_q      <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            ifpc_q      <= ifpc_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Output wiring: memory address is the live PC.
    always_comb begin
        imem_addr    = pc_q;
        if_id_instr  = instr_q;
        if_id_pc     = ifpc_q;
        if_id_valid  = valid_q;
        stall_cycles = stall_cnt_q;
        flush_count  = flush_cnt_q;
    end

endmodule
